// File: rtl/up_counter_mod.sv
// Modulo-MODULUS up counter with enable, sync clear, checked parallel load,
// combinational terminal-count carry for cascading, and a sticky wrap flag.
module up_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             load_err
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_cfg_err
      $error("up_counter_mod: MODULUS=%0d outside 2..2**WIDTH (WIDTH=%0d)", MODULUS, WIDTH);
    end
  endgenerate

  // MOD_EXT is one bit wider so MODULUS = 2**WIDTH stays representable.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             load_err_q, load_err_d;
  logic             at_max;
  logic             d_legal;

  assign at_max  = (count_q == MAX_CNT);
  assign d_legal = ({1'b0, d} < MOD_EXT);

  always_comb begin
    count_d    = count_q;
    ovf_d      = ovf_q;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      // An illegal value is rejected outright (no clamp) and still blocks counting.
      if (d_legal) count_d = d;
      else         load_err_d = 1'b1;
    end else if (en) begin
      if (at_max) begin
        count_d = '0;
        ovf_d   = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = count_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;
  assign tc       = en & ~clr & ~load & at_max;

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed bench: free-running mod-16, mod-10 cascade, and a mod-10 instance
// for load, priority, hold/sticky and asynchronous reset behaviour.
module tb_up_counter_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // mod-16 instance
  logic       rst_a, en_a, clr_a, load_a;
  logic [3:0] d_a, q_a;
  logic       tc_a, ovf_a, le_a;
  // mod-10 general instance
  logic       rst_b, en_b, clr_b, load_b;
  logic [3:0] d_b, q_b;
  logic       tc_b, ovf_b, le_b;
  // mod-10 cascade
  logic       rst_c, en_c;
  logic [3:0] q_u, q_t;
  logic       tc_u, tc_t, ovf_u, ovf_t, le_u, le_t;

  up_counter_mod #(.WIDTH(4), .MODULUS(16)) u_a (
    .clk(clk), .reset(rst_a), .en(en_a), .clr(clr_a), .load(load_a), .d(d_a),
    .q(q_a), .tc(tc_a), .ovf(ovf_a), .load_err(le_a));

  up_counter_mod #(.WIDTH(4), .MODULUS(10)) u_b (
    .clk(clk), .reset(rst_b), .en(en_b), .clr(clr_b), .load(load_b), .d(d_b),
    .q(q_b), .tc(tc_b), .ovf(ovf_b), .load_err(le_b));

  up_counter_mod #(.WIDTH(4), .MODULUS(10)) u_units (
    .clk(clk), .reset(rst_c), .en(en_c), .clr(1'b0), .load(1'b0), .d(4'd0),
    .q(q_u), .tc(tc_u), .ovf(ovf_u), .load_err(le_u));

  up_counter_mod #(.WIDTH(4), .MODULUS(10)) u_tens (
    .clk(clk), .reset(rst_c), .en(tc_u), .clr(1'b0), .load(1'b0), .d(4'd0),
    .q(q_t), .tc(tc_t), .ovf(ovf_t), .load_err(le_t));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cur;
    rst_a = 1'b1; en_a = 1'b0; clr_a = 1'b0; load_a = 1'b0; d_a = 4'd0;
    rst_b = 1'b1; en_b = 1'b0; clr_b = 1'b0; load_b = 1'b0; d_b = 4'd0;
    rst_c = 1'b1; en_c = 1'b0;
    #2;
    chk("rst_q_a", 32'(q_a), 0);
    chk("rst_ovf_a", 32'(ovf_a), 0);
    chk("rst_le_a", 32'(le_a), 0);
    chk("rst_q_b", 32'(q_b), 0);
    #10;
    rst_a = 1'b0; rst_b = 1'b0;

    // ---- mod-16 free run, reset mid-stream ----
    en_a = 1'b1;
    tick(); tick(); tick();
    chk("a_pre_q3", 32'(q_a), 3);
    #2 rst_a = 1'b1;
    #1;
    chk("a_midrst_q", 32'(q_a), 0);
    tick();
    chk("a_rst_hold_q", 32'(q_a), 0);
    #2 rst_a = 1'b0;
    #1;
    cur = 0;
    for (int i = 1; i <= 17; i++) begin
      chk("a_tc", 32'(tc_a), (cur == 15) ? 1 : 0);
      tick();
      cur = (cur + 1) % 16;
      chk("a_q", 32'(q_a), cur);
      chk("a_ovf", 32'(ovf_a), (i >= 16) ? 1 : 0);
    end
    en_a = 1'b0;

    // ---- mod-10 cascade, 100 enabled cycles ----
    @(negedge clk);
    rst_c = 1'b0;
    en_c  = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk("c_units", 32'(q_u), i % 10);
      chk("c_tens", 32'(q_t), (i / 10) % 10);
    end
    chk("c_tens_ovf", 32'(ovf_t), 1);
    chk("c_units_ovf", 32'(ovf_u), 1);
    en_c = 1'b0;

    // ---- load (mod-10) ----
    load_b = 1'b1; d_b = 4'd7;
    tick();
    chk("ld7_q", 32'(q_b), 7);
    chk("ld7_le", 32'(le_b), 0);
    d_b = 4'd12; en_b = 1'b1;
    tick();
    chk("ld12_q", 32'(q_b), 7);
    chk("ld12_le", 32'(le_b), 1);
    load_b = 1'b0; en_b = 1'b0;
    tick();
    chk("ld12_le_clr", 32'(le_b), 0);
    chk("ld12_q_hold", 32'(q_b), 7);
    load_b = 1'b1; d_b = 4'd10;
    tick();
    chk("ld10_q", 32'(q_b), 7);
    chk("ld10_le", 32'(le_b), 1);
    d_b = 4'd9;
    tick();
    chk("ld9_q", 32'(q_b), 9);
    chk("ld9_le", 32'(le_b), 0);

    // ---- priority ----
    load_b = 1'b0; en_b = 1'b1;
    tick();
    chk("pr_wrap_q", 32'(q_b), 0);
    chk("pr_wrap_ovf", 32'(ovf_b), 1);
    load_b = 1'b1; en_b = 1'b0; d_b = 4'd9;
    tick();
    chk("pr_q9", 32'(q_b), 9);
    chk("pr_ovf_kept", 32'(ovf_b), 1);
    clr_b = 1'b1; load_b = 1'b1; d_b = 4'd3; en_b = 1'b1;
    #1;
    chk("pr_clr_tc", 32'(tc_b), 0);
    tick();
    chk("pr_clr_q", 32'(q_b), 0);
    chk("pr_clr_ovf", 32'(ovf_b), 0);
    clr_b = 1'b0; d_b = 4'd9;
    #1;
    chk("pr_ld_tc", 32'(tc_b), 0);
    tick();
    chk("pr_ld9_q", 32'(q_b), 9);
    d_b = 4'd4;
    #1;
    chk("pr_ld_at_max_tc", 32'(tc_b), 0);
    tick();
    chk("pr_ld_at_max_q", 32'(q_b), 4);
    chk("pr_ld_at_max_ovf", 32'(ovf_b), 0);

    // ---- hold ----
    load_b = 1'b0; en_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_q", 32'(q_b), 4);
      chk("hold_tc", 32'(tc_b), 0);
    end
    load_b = 1'b1; d_b = 4'd9;
    tick();
    load_b = 1'b0;
    #1;
    chk("tc_en0_at_max", 32'(tc_b), 0);
    en_b = 1'b1;
    #1;
    chk("tc_en1_at_max", 32'(tc_b), 1);

    // ---- sticky ovf ----
    tick();
    chk("st_wrap_q", 32'(q_b), 0);
    chk("st_wrap_ovf", 32'(ovf_b), 1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("st_q", 32'(q_b), i % 10);
      chk("st_ovf", 32'(ovf_b), 1);
    end
    en_b = 1'b0; clr_b = 1'b1;
    tick();
    chk("st_clr_ovf", 32'(ovf_b), 0);
    chk("st_clr_q", 32'(q_b), 0);
    clr_b = 1'b0;

    // ---- async reset at q=5 with ovf set ----
    load_b = 1'b1; d_b = 4'd9;
    tick();
    load_b = 1'b0; en_b = 1'b1;
    tick();
    chk("ar_ovf_set", 32'(ovf_b), 1);
    en_b = 1'b0; load_b = 1'b1; d_b = 4'd5;
    tick();
    load_b = 1'b0; en_b = 1'b1;
    chk("ar_q5", 32'(q_b), 5);
    #2 rst_b = 1'b1;
    #1;
    chk("ar_q", 32'(q_b), 0);
    chk("ar_ovf", 32'(ovf_b), 0);
    #1 rst_b = 1'b0;
    tick();
    chk("ar_resume_q", 32'(q_b), 1);
    chk("ar_resume_ovf", 32'(ovf_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/up_counter_mod.md
# up_counter_mod

Synchronous modulo-N up counter: the counting-up counterpart to the team's 4-bit down counter. Counts 0 to MODULUS-1 and wraps to 0. Adds count enable, synchronous clear, parallel load, a terminal-count carry for cascading stages, and a sticky overflow flag. Used as a timebase or prescaler stage and as a cascadable digit (e.g. BCD with MODULUS=10).

## Interface
- WIDTH, 4, counter width in bits.
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2 ≤ MODULUS ≤ 2**WIDTH. Out-of-range values are a configuration error; simulation flags them at elaboration.
- clk  input  1  clock. Rising edge active.
- reset  input  1  reset: asynchronous, active-high.
- en  input  1  count enable. Increment on the edge when high.
- clr  input  1  synchronous clear to 0. Highest priority.
- load  input  1  synchronous parallel load of d.
- d  input  WIDTH  load value.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal-count carry (combinational).
- ovf  output  1  sticky wrap flag (registered).
- load_err  output  1  one-cycle flag marking an illegal load value (registered).

## Operation
- Structure:
  - A state register holds the count.
  - Combinational next-state logic.
  - q driven directly from the state register.
- Priority per rising edge: clr > load > en > hold.
- clr=1: q←0, ovf←0, load_err←0.
- load=1 (clr=0):
  - d < MODULUS: q←d, load_err←0.
  - d ≥ MODULUS: q holds, load_err←1 for exactly one cycle. The load is rejected and is not clamped.
  - ovf unchanged in both cases.
- en=1 (clr=0, load=0):
  - q < MODULUS-1: q←q+1.
  - q = MODULUS-1: q←0 and ovf←1 (wrap).
- All inputs low: q holds, ovf holds, load_err←0.
- load_err is 0 on every cycle except the cycle after a rejected load.
- tc = en & ~clr & ~load & (q == MODULUS-1).
  - Asserted during the cycle whose rising edge performs the wrap.
  - Intended to drive en of the next cascaded stage.
- Arithmetic:
  - Increment is WIDTH bits wide.
  - The wrap is explicit on compare with MODULUS-1. It never relies on natural 2**WIDTH rollover, except when MODULUS = 2**WIDTH, where both give the same result.
  - The d compare is unsigned, at full WIDTH.
- ovf stays set until clr or reset. Further wraps keep it at 1.

## Timing
- Reset:
  - While reset is high: q=0, ovf=0, load_err=0, independent of clk.
  - On reset deassertion, the first increment occurs on the first rising edge with en=1.
- Latency:
  - q, ovf and load_err update one edge after the qualifying inputs are sampled.
  - tc has zero latency and follows q, en, clr and load combinationally within the same cycle.
- Reset mid-count: q returns to 0 immediately, and a wrap in flight is lost (ovf=0).
- Simultaneous events:
  - clr+load+en: clear wins.
  - load+en at q=MODULUS-1: load wins, tc=0, ovf unchanged.
  - Rejected load with en=1: q holds and does not count. load dominates en even when d is illegal.
- Throughput: one count per enabled cycle. No idle cycles at the wrap: the sequence is MODULUS-1, 0, 1, …

## Test plan
- Reset and free run (defaults): assert reset mid-stream, then en=1 for 17 edges.
  - Required: q=0 during reset.
  - Sequence 1,2,…,15,0,1.
  - tc high only while q=15.
  - ovf rises on the edge where q goes 15→0.
- Modulo-10 cascade (WIDTH=4, MODULUS=10): two instances, with units tc driving tens en; run 100 enabled cycles from reset.
  - Required: units wrap 9→0 each 10 cycles.
  - Tens reads 9 after 99 cycles.
  - Both read 0 after 100 cycles, and tens ovf=1.
- Load (MODULUS=10):
  - load d=7 → q=7, load_err=0.
  - load d=12 with en=1 → q stays 7, load_err=1 for one cycle, then 0.
- Priority: at q=9 (MODULUS=10) apply clr=1, load=1, d=3, en=1 → q=0, ovf=0.
  - Next cycle: load=1, d=9, en=1 → q=9 and tc=0 during the load cycle.
- Hold and sticky:
  - en=0 for 5 cycles → q unchanged, tc=0.
  - After a wrap, 20 more enabled cycles leave ovf=1.
  - A single clr cycle clears ovf to 0.
- Async reset: assert reset between clock edges while q=5, en=1 → q=0, ovf=0 before the next edge. Counting resumes from 1 on the first enabled edge after release.
